// File: rtl/nibble_serial_adder_ctrl.sv
// nibble_serial_adder_ctrl
//
// Adds two W-bit operands (W = 4*NIBBLES) by running one 4-bit ripple-carry
// slice per clock, least-significant nibble first. A registered carry links
// successive nibbles. The master sees a start/busy/done handshake.
//
// Optional feature macro: NIBBLE_SERIAL_ADDER_SUB_EN
//   When defined, a 'sub' input is added. With sub=1 the block computes
//   a - b mod 2^W. In that mode cout=1 means no borrow.
//
// Ports:
//   clk    in   1  rising-edge clock
//   rst    in   1  synchronous, active-high reset
//   start  in   1  request, sampled only while busy=0
//   a, b   in   W  operands, latched on the accepting edge
//   cin    in   1  carry-in to nibble 0, latched on the accepting edge
//   sub    in   1  (macro only) subtract select, latched on the accepting edge
//   busy   out  1  operation in progress
//   done   out  1  one-cycle pulse; s/cout are valid in that cycle
//   s      out  W  registered sum, held between completions
//   cout   out  1  registered carry out of the top nibble

module nibble_serial_adder_ctrl #(
  parameter int NIBBLES = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   start,
  input  logic [4*NIBBLES-1:0]   a,
  input  logic [4*NIBBLES-1:0]   b,
  input  logic                   cin,
`ifdef NIBBLE_SERIAL_ADDER_SUB_EN
  input  logic                   sub,
`endif
  output logic                   busy,
  output logic                   done,
  output logic [4*NIBBLES-1:0]   s,
  output logic                   cout
);

  localparam int W    = 4 * NIBBLES;
  localparam int IDXW = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;
  localparam logic [IDXW-1:0] LAST_IDX = IDXW'(NIBBLES - 1);

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

  state_t            state_q, state_d;
  logic [W-1:0]      a_q, a_d;
  logic [W-1:0]      b_q, b_d;
  logic              carry_q, carry_d;
  logic [IDXW-1:0]   idx_q, idx_d;
  logic [W-1:0]      acc_q, acc_d;
  logic [W-1:0]      s_q, s_d;
  logic              cout_q, cout_d;
  logic              done_q, done_d;

  // Bit offset of the current nibble: idx * 4.
  logic [IDXW+1:0]   bit_base;
  logic [3:0]        a_nib;
  logic [3:0]        b_nib;
  logic [3:0]        sum4;
  logic [4:0]        carry_chain;

  // Operand B and initial carry as captured on the accepting edge. In
  // subtract mode B is inverted and the +1 comes in through the carry.
  logic [W-1:0]      b_load;
  logic              carry_load;

`ifdef NIBBLE_SERIAL_ADDER_SUB_EN
  assign b_load     = sub ? ~b : b;
  assign carry_load = sub ? 1'b1 : cin;
`else
  assign b_load     = b;
  assign carry_load = cin;
`endif

  // 4-bit ripple slice: per bit, the sum is a XOR and the carry is a majority.
  always_comb begin
    bit_base       = {idx_q, 2'b00};
    a_nib          = a_q[bit_base +: 4];
    b_nib          = b_q[bit_base +: 4];
    sum4           = '0;
    carry_chain    = '0;
    carry_chain[0] = carry_q;
    for (int i = 0; i < 4; i++) begin
      sum4[i]          = a_nib[i] ^ b_nib[i] ^ carry_chain[i];
      carry_chain[i+1] = (a_nib[i] & b_nib[i]) |
                         (a_nib[i] & carry_chain[i]) |
                         (b_nib[i] & carry_chain[i]);
    end
  end

  // Next-state and datapath control
  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    carry_d = carry_q;
    idx_d   = idx_q;
    acc_d   = acc_q;
    s_d     = s_q;
    cout_d  = cout_q;
    done_d  = 1'b0;

    case (state_q)
      IDLE: begin
        if (start) begin
          a_d     = a;
          b_d     = b_load;
          carry_d = carry_load;
          idx_d   = '0;
          state_d = RUN;
        end
      end

      RUN: begin
        acc_d[bit_base +: 4] = sum4;
        carry_d              = carry_chain[4];
        if (idx_q == LAST_IDX) begin
          // s takes the accumulator including the nibble written this cycle.
          s_d     = acc_d;
          cout_d  = carry_chain[4];
          done_d  = 1'b1;
          idx_d   = '0;
          state_d = IDLE;
        end else begin
          idx_d = idx_q + 1'b1;
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      a_q     <= '0;
      b_q     <= '0;
      carry_q <= 1'b0;
      idx_q   <= '0;
      acc_q   <= '0;
      s_q     <= '0;
      cout_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      carry_q <= carry_d;
      idx_q   <= idx_d;
      acc_q   <= acc_d;
      s_q     <= s_d;
      cout_q  <= cout_d;
      done_q  <= done_d;
    end
  end

  assign busy = (state_q == RUN);
  assign done = done_q;
  assign s    = s_q;
  assign cout = cout_q;

endmodule

// File: tb/tb_nibble_serial_adder_ctrl.sv
// Testbench for nibble_serial_adder_ctrl (NIBBLES = 4, W = 16).
// Expected results are queued when an operation is accepted and popped when
// the DUT raises done.

module tb_nibble_serial_adder_ctrl;

  localparam int NIBBLES = 4;
  localparam int W       = 4 * NIBBLES;

  logic          clk;
  logic          rst;
  logic          start;
  logic [W-1:0]  a;
  logic [W-1:0]  b;
  logic          cin;
  logic          sub;
  logic          busy;
  logic          done;
  logic [W-1:0]  s;
  logic          cout;

  typedef struct packed {
    logic [W-1:0] s;
    logic         cout;
  } exp_t;

  exp_t          sb_q[$];
  int            checks;
  int            errors;
  logic [W-1:0]  prev_s;

  nibble_serial_adder_ctrl #(.NIBBLES(NIBBLES)) dut (
    .clk   (clk),
    .rst   (rst),
    .start (start),
    .a     (a),
    .b     (b),
    .cin   (cin),
`ifdef NIBBLE_SERIAL_ADDER_SUB_EN
    .sub   (sub),
`endif
    .busy  (busy),
    .done  (done),
    .s     (s),
    .cout  (cout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance one rising edge; outputs are sampled and inputs changed 1 ns later.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    checks++;
    assert (observed === expected)
    else begin
      errors++;
      $error("[TB] FAIL %s: observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  // Reference model: plain W+1 bit arithmetic.
  function automatic exp_t model(input logic [W-1:0] ma, input logic [W-1:0] mb,
                                 input logic mcin, input logic msub);
    logic [W:0] full;
    exp_t       r;
    if (msub) full = {1'b0, ma} + {1'b0, ~mb} + (W+1)'(1);
    else      full = {1'b0, ma} + {1'b0, mb} + (W+1)'(mcin);
    r.s    = full[W-1:0];
    r.cout = full[W];
    return r;
  endfunction

  // Drive a request, queue its expected result, and step over the accepting edge.
  task automatic applyStimulus(input logic [W-1:0] ta, input logic [W-1:0] tb,
                               input logic tcin, input logic tsub);
    a     = ta;
    b     = tb;
    cin   = tcin;
    sub   = tsub;
    start = 1'b1;
    sb_q.push_back(model(ta, tb, tcin, tsub));
    tick();
    start = 1'b0;
    checkOutput("busy_after_accept", 32'(busy), 32'd1);
  endtask

  // Compare the DUT result against the head of the scoreboard.
  task automatic popAndCheck(input string tag);
    exp_t e;
    if (sb_q.size() == 0) begin
      checks++;
      errors++;
      $display("[TB] FAIL %s: done with empty scoreboard, observed s=%0h", tag, s);
    end else begin
      e = sb_q.pop_front();
      checkOutput({tag, "_s"}, 32'(s), 32'(e.s));
      checkOutput({tag, "_cout"}, 32'(cout), 32'(e.cout));
    end
  endtask

  // Wait (bounded) for done, checking s is held and latency is NIBBLES edges.
  task automatic waitDone(input string tag);
    int  n;
    bit  seen;
    seen = 1'b0;
    for (n = 1; n <= 3 * NIBBLES; n++) begin
      tick();
      if (done) begin
        seen = 1'b1;
        break;
      end
      checkOutput({tag, "_s_held"}, 32'(s), 32'(prev_s));
    end
    if (!seen) begin
      checks++;
      errors++;
      $display("[TB] FAIL %s_timeout: observed no done, required done within %0d cycles",
               tag, 3 * NIBBLES);
    end else begin
      checkOutput({tag, "_latency"}, 32'(n), 32'(NIBBLES));
      checkOutput({tag, "_busy_in_done"}, 32'(busy), 32'd0);
      popAndCheck(tag);
      prev_s = s;
    end
  endtask

  task automatic runOp(input string tag, input logic [W-1:0] ta,
                       input logic [W-1:0] tb, input logic tcin, input logic tsub);
    applyStimulus(ta, tb, tcin, tsub);
    waitDone(tag);
    tick();
    checkOutput({tag, "_done_drop"}, 32'(done), 32'd0);
  endtask

  initial begin
    checks = 0;
    errors = 0;
    rst    = 1'b1;
    start  = 1'b1;
    a      = 16'hFFFF;
    b      = 16'hFFFF;
    cin    = 1'b1;
    sub    = 1'b0;

    // Reset held for two cycles with start high: nothing may start.
    tick();
    tick();
    checkOutput("rst_busy", 32'(busy), 32'd0);
    checkOutput("rst_done", 32'(done), 32'd0);
    checkOutput("rst_s", 32'(s), 32'h0000);
    checkOutput("rst_cout", 32'(cout), 32'd0);
    rst   = 1'b0;
    start = 1'b0;
    tick();
    checkOutput("post_rst_busy", 32'(busy), 32'd0);
    prev_s = 16'h0000;

    // Basic add, with constant expectation from the plan.
    applyStimulus(16'h1234, 16'h4321, 1'b0, 1'b0);
    waitDone("basic");
    checkOutput("basic_const", 32'(s), 32'h5555);
    tick();
    checkOutput("basic_done_drop", 32'(done), 32'd0);
    checkOutput("basic_s_hold", 32'(s), 32'h5555);

    // Full carry ripple cases.
    runOp("ripple1", 16'hFFFF, 16'h0000, 1'b1, 1'b0);
    runOp("ripple2", 16'h8000, 16'h8000, 1'b0, 1'b0);
    checkOutput("ripple2_cout_hold", 32'(cout), 32'd1);

    // Ignored start during RUN, then back-to-back start in the done cycle.
    applyStimulus(16'h0001, 16'h0001, 1'b0, 1'b0);
    tick();
    a     = 16'hAAAA;
    b     = 16'h5555;
    start = 1'b1;
    tick();
    start = 1'b0;
    tick();
    tick();
    checkOutput("b2b_first_done", 32'(done), 32'd1);
    popAndCheck("b2b_first");
    checkOutput("b2b_first_const", 32'(s), 32'h0002);
    prev_s = s;
    applyStimulus(16'h00FF, 16'h0001, 1'b0, 1'b0);
    checkOutput("b2b_done_single", 32'(done), 32'd0);
    waitDone("b2b_second");
    checkOutput("b2b_second_const", 32'(s), 32'h0100);
    // The ignored AAAA+5555 request must not have been queued.
    for (int i = 0; i < NIBBLES + 2; i++) begin
      tick();
      checkOutput("no_queued_done", 32'(done), 32'd0);
      checkOutput("no_queued_busy", 32'(busy), 32'd0);
    end

    // Reset mid-operation aborts with no done pulse and clears s/cout.
    a     = 16'h1111;
    b     = 16'h2222;
    cin   = 1'b0;
    start = 1'b1;
    tick();
    start = 1'b0;
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    checkOutput("abort_busy", 32'(busy), 32'd0);
    checkOutput("abort_done", 32'(done), 32'd0);
    checkOutput("abort_s", 32'(s), 32'h0000);
    checkOutput("abort_cout", 32'(cout), 32'd0);
    for (int i = 0; i < NIBBLES + 2; i++) begin
      tick();
      checkOutput("abort_no_done", 32'(done), 32'd0);
    end
    prev_s = 16'h0000;

    // A few random additions against the model.
    for (int i = 0; i < 4; i++) begin
      runOp("rand_add", 16'($urandom), 16'($urandom), 1'($urandom_range(1)), 1'b0);
    end

`ifdef NIBBLE_SERIAL_ADDER_SUB_EN
    runOp("sub1", 16'h0005, 16'h0007, 1'b0, 1'b1);
    checkOutput("sub1_const_s", 32'(s), 32'hFFFE);
    checkOutput("sub1_const_cout", 32'(cout), 32'd0);
    runOp("sub2", 16'h0007, 16'h0005, 1'b1, 1'b1);
    checkOutput("sub2_const_s", 32'(s), 32'h0002);
    checkOutput("sub2_const_cout", 32'(cout), 32'd1);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/nibble_serial_adder_ctrl.md
Name: nibble_serial_adder_ctrl

Overview:
- Sequencer that adds two wide operands by running one 4-bit ripple-carry add slice per clock, least-significant nibble first.
- Carries between nibbles through a registered carry.
- Sits between a requesting master (start/busy/done handshake) and the 4-bit adder datapath, so one 4-bit slice serves arbitrarily wide operands.

Parameters:
- NIBBLES, 4, number of 4-bit nibbles per operand; operand width W = 4*NIBBLES; legal range 1..64.

Ports:
- clk  input  1  single clock; all state updates on rising edge.
- rst  input  1  synchronous, active-high reset.
- start  input  1  request; sampled only when busy=0.
- a  input  W  operand A; sampled on the accepting edge only.
- b  input  W  operand B; sampled on the accepting edge only.
- cin  input  1  carry-in to nibble 0; sampled on the accepting edge only.
- busy  output  1  high while an operation is in progress.
- done  output  1  one-cycle pulse; s/cout valid in that cycle.
- s  output  W  sum result, registered.
- cout  output  1  carry out of the top nibble, registered.

Behaviour:
- Clock and reset: one clock, clk. Reset rst is synchronous and active-high.
- Reset values: state=IDLE, busy=0, done=0, s=0, cout=0, idx=0, carry=0, accumulator=0.
- rst has priority over all other inputs. Asserting rst mid-RUN aborts the operation: no done pulse, and s/cout return to 0.
- States: IDLE, RUN.
- IDLE:
  - busy=0.
  - On an edge with start=1, latch a, b and cin into internal registers (carry <= cin), set idx=0 and busy=1, then go to RUN.
  - start=0 leaves the state unchanged.
- RUN:
  - Each edge computes nibble idx: {c, sum4} = a_r[idx] + b_r[idx] + carry. Per bit, the sum is the XOR of the three inputs and the carry is the majority function of them.
  - sum4 is written to accumulator nibble idx; carry <= c; idx <= idx+1.
  - On the edge that processes idx = NIBBLES-1: s <= full accumulator including the final nibble, cout <= c, done <= 1, busy <= 0, and the state returns to IDLE.
- Latency: if start is accepted on edge E0, nibble i is processed on edge E(i+1). done is high for exactly the one cycle following edge E(NIBBLES). Throughput is one operation per NIBBLES+1 cycles minimum.
- s and cout hold the previous result throughout RUN. They change only on the completing edge, and are otherwise held until the next completion or reset.
- done deasserts on the edge after it rises, regardless of inputs.
- start while busy=1 is ignored, not queued; the operand inputs are don't-care during RUN.
- start high during the done cycle (state IDLE) is accepted normally, giving back-to-back operations.
- NIBBLES=1: RUN lasts one edge; done follows the accepting edge by exactly one cycle.
- Wrap-around: the sum is modulo 2^W; overflow beyond W bits is reported only via cout.
- idx width is clog2(NIBBLES) with a minimum of 1 bit. idx never exceeds NIBBLES-1.

Optional Feature:
- Macro: NIBBLE_SERIAL_ADDER_SUB_EN.
- Defined:
  - Adds port sub (input, 1), sampled with the operands on the accepting edge.
  - If sub=1, b is latched bit-inverted and carry is initialised to 1 (cin is ignored), giving s = a - b mod 2^W. In this mode cout=1 means no borrow (a >= b unsigned).
  - If sub=0, behaviour is identical to the undefined case.
- Undefined: no sub port; the block only adds.

Test Plan:
- Reset: hold rst=1 for 2 cycles with start=1 -> busy=0, done=0, s=16'h0000, cout=0; no operation starts.
- Basic add (NIBBLES=4): a=16'h1234, b=16'h4321, cin=0, start pulse -> done high exactly in the 5th cycle after the accepting edge; s=16'h5555, cout=0; s held at its previous value until then.
- Full carry ripple: a=16'hFFFF, b=16'h0000, cin=1 -> s=16'h0000, cout=1. Also a=16'h8000, b=16'h8000, cin=0 -> s=16'h0000, cout=1.
- Ignored start and back-to-back:
  - Accept a=16'h0001, b=16'h0001.
  - Pulse start with a=16'hAAAA, b=16'h5555 in RUN cycle 2 -> first result s=16'h0002 with a single done.
  - Start asserted in the done cycle with a=16'h00FF, b=16'h0001 -> accepted; s=16'h0100 after 5 more cycles.
- Reset mid-operation: start a=16'h1111, b=16'h2222, then rst=1 on RUN cycle 2 -> busy=0 next cycle, done never asserts, s=16'h0000, cout=0.
- With NIBBLE_SERIAL_ADDER_SUB_EN:
  - a=16'h0005, b=16'h0007, sub=1 -> s=16'hFFFE, cout=0.
  - a=16'h0007, b=16'h0005, sub=1 -> s=16'h0002, cout=1.
